// File: rtl/quad_motor_mixer_fsm.sv
// Quad X-frame motor controller: arm/takeoff/fly/land FSM, proportional
// gyro mixer with clamping, and per-motor PWM with wrap-aligned duty updates.
module quad_motor_mixer_fsm #(
  parameter int DUTY_W     = 8,
  parameter int GYRO_W     = 12,
  parameter int CORR_SHIFT = 2,
  parameter int RAMP_DIV   = 4,
  parameter int RAMP_STEP  = 16,
  parameter int HOVER_DUTY = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [GYRO_W-1:0] gyro_x,
  input  logic signed [GYRO_W-1:0] gyro_y,
  input  logic signed [GYRO_W-1:0] gyro_z,
  input  logic                     receiver_ch5,
  input  logic [DUTY_W-1:0]        throttle,
  output logic [3:0]               motor_pwm,
  output logic [4*DUTY_W-1:0]      motor_duty,
  output logic                     takeoff,
  output logic                     landing,
  output logic                     armed
);

  localparam int MW = DUTY_W + GYRO_W + 2;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DUTY_W-1:0]    DMAX   = '1;
  localparam logic [DUTY_W-1:0]    HOV    = DUTY_W'(HOVER_DUTY);
  localparam logic [DUTY_W:0]      STEP_X = (DUTY_W+1)'(RAMP_STEP);
  localparam logic signed [MW-1:0] DMAX_S = MW'(2**DUTY_W - 1);
  // Per-motor correction signs, bit i = motor i (FL, FR, RR, RL); 1 = subtract.
  localparam logic [3:0] R_NEG = 4'b0110;
  localparam logic [3:0] P_NEG = 4'b1100;
  localparam logic [3:0] Y_NEG = 4'b0101;

  typedef enum logic [1:0] {IDLE, TAKEOFF, FLY, LANDING} state_t;

  state_t                  state_q, state_n;
  logic [DUTY_W-1:0]       base_q, base_n;
  logic [RW-1:0]           ramp_q, ramp_n;
  logic [DUTY_W-1:0]       pwm_cnt;
  logic                    arm_d;
  logic                    arm_rise, step;
  logic [DUTY_W:0]         up, dn;
  logic [3:0][DUTY_W-1:0]  duty_q, tgt;
  logic [3:0]              pwm_n;
  logic signed [MW-1:0]    gx_e, gy_e, gz_e, r_c, p_c, y_c, bs, sum;

  assign arm_rise = receiver_ch5 & ~arm_d;
  assign step     = (ramp_q == RW'(RAMP_DIV - 1));

  // State, base duty, ramp divider and arm edge register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      ramp_q  <= '0;
      arm_d   <= 1'b0;
    end else begin
      state_q <= state_n;
      base_q  <= base_n;
      ramp_q  <= ramp_n;
      arm_d   <= receiver_ch5;
    end
  end

  // Next state and base; transitions use the post-step base so FLY/IDLE
  // are entered on the same edge the ramp reaches its end value.
  always_comb begin
    state_n = state_q;
    base_n  = base_q;
    up      = {1'b0, base_q} + STEP_X;
    dn      = {1'b0, base_q} - STEP_X;
    unique case (state_q)
      IDLE: begin
        base_n = '0;
        if (arm_rise) state_n = TAKEOFF;
      end
      TAKEOFF: begin
        if (step) base_n = (up >= {1'b0, HOV}) ? HOV : up[DUTY_W-1:0];
        if (!receiver_ch5)      state_n = LANDING;
        else if (base_n == HOV) state_n = FLY;
      end
      FLY: begin
        base_n = throttle;
        if (!receiver_ch5) state_n = LANDING;
      end
      LANDING: begin
        if (step) base_n = ({1'b0, base_q} > STEP_X) ? dn[DUTY_W-1:0] : '0;
        if (base_n == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Divider restarts on every state entry and after each step.
    ramp_n = ((state_n != state_q) || step) ? '0 : ramp_q + 1'b1;
  end

  assign gx_e = MW'(gyro_x);
  assign gy_e = MW'(gyro_y);
  assign gz_e = MW'(gyro_z);

  // Mixer: wide signed sum per motor, clamped to [0, DMAX]; base only outside FLY.
  always_comb begin
    r_c = gx_e >>> CORR_SHIFT;
    p_c = gy_e >>> CORR_SHIFT;
    y_c = gz_e >>> CORR_SHIFT;
    bs  = $signed({{(MW-DUTY_W){1'b0}}, base_q});
    sum = '0;
    tgt = '0;
    for (int i = 0; i < 4; i++) begin
      sum = bs + (R_NEG[i] ? -r_c : r_c)
               + (P_NEG[i] ? -p_c : p_c)
               + (Y_NEG[i] ? -y_c : y_c);
      if (state_q != FLY)  tgt[i] = base_q;
      else if (sum < 0)    tgt[i] = '0;
      else if (sum > DMAX_S) tgt[i] = DMAX;
      else                 tgt[i] = sum[DUTY_W-1:0];
    end
  end

  // PWM compare against the active duty.
  always_comb begin
    pwm_n = '0;
    for (int i = 0; i < 4; i++) pwm_n[i] = (pwm_cnt < duty_q[i]);
  end

  // Free-running PWM counter; duties only reload at the wrap to stay glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt   <= '0;
      duty_q    <= '0;
      motor_pwm <= '0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (pwm_cnt == DMAX) duty_q <= tgt;
      motor_pwm <= pwm_n;
    end
  end

  assign motor_duty = duty_q;
  assign takeoff    = (state_q == TAKEOFF);
  assign landing    = (state_q == LANDING);
  assign armed      = (state_q != IDLE);

endmodule
